sensor_packet_builder: RTL and testbench
========================================

# sensor_packet_builder

Assembles one 32-byte sensor telemetry packet per accepted IMU sample and hands it to the SPI slave stage through the `data_bytes`/`data_ready`/`data_ack` handshake. The block captures a sample and stamps it with a sequence number, a timestamp and a drop count. It computes a checksum at one byte per cycle, then holds the packet stable until the SPI stage acknowledges it. One pending-sample register absorbs a single sample that arrives while a packet is in flight; further samples are counted as drops.

## Interface
- `TS_DIV`, 1000: clk cycles per timestamp tick (≥1).
- `SYNC_BYTE`, 8'hAA: packet byte 0.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; sample fields are valid in the same cycle.
- `quat_w`, `quat_x`, `quat_y`, `quat_z` in 16 each: quaternion components.
- `accel_x`, `accel_y`, `accel_z` in 16 each: accelerometer axes.
- `gyro_x`, `gyro_y`, `gyro_z` in 16 each: gyroscope axes.
- `status_flags` in 8: sensor status.
- `data_bytes` out 8 x [0:31]: packet, byte 0 first.
- `data_ready` out 1: packet complete and stable.
- `data_ack` in 1: one-cycle pulse from the SPI stage; the packet has been consumed.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, BUILD, READY.
- **Packet layout (multi-byte fields big-endian):**
  - 0: `SYNC_BYTE`
  - 1: seq
  - 2–5: timestamp
  - 6–13: quat w, x, y, z
  - 14–19: accel x, y, z
  - 20–25: gyro x, y, z
  - 26: flags
  - 27: drop_cnt
  - 28–30: 8'h00
  - 31: checksum = (−Σ bytes 0..30) mod 256, so the byte sum of the whole packet is 0 mod 256.
- **Capture:** bytes 0..30 are written into `data_bytes` in one edge.
  - seq takes the current `seq_cnt`; `seq_cnt` then increments, wrapping 255→0.
  - Byte 27 takes the current `drop_cnt`; `drop_cnt` then clears to 0, or to 1 if a drop occurs on the same edge.
  - Timestamp takes the current `ts_cnt`.
- **IDLE:** `sample_valid` → capture, checksum accumulator = 0, idx = 0, go to BUILD.
- **BUILD:** each cycle acc += `data_bytes[idx]`, idx++.
  - After idx 30 is accumulated, byte 31 = −acc, `data_ready` goes to 1 and the state goes to READY.
- **READY:** `data_bytes` and `data_ready` are held.
  - On `data_ack`, `data_ready` goes to 0.
  - If `pending_valid`: capture the pending sample, clear `pending_valid`, go to BUILD.
  - Else if `sample_valid` this cycle: capture it directly, go to BUILD.
  - Else: go to IDLE.
- **`sample_valid` while not IDLE** (excluding the READY+`data_ack` capture case above): store the sample in pending and set `pending_valid`.
  - If `pending_valid` was already 1, overwrite the stored sample and increment `drop_cnt`, saturating at 255.
  - Simultaneous READY+`data_ack`+`pending_valid`+`sample_valid`: the pending sample is captured and the new sample becomes pending with no drop.
- **Timestamp:** a prescaler counts 0..`TS_DIV`−1; `ts_cnt` (32-bit) increments at each prescaler wrap and wraps at 2^32.
- **`data_ack`:** ignored outside READY.
- **Reset:** `rst_n` low at any time, including mid-BUILD, returns the block to IDLE immediately and discards the partial packet and any pending sample.

## Timing
- **Reset values:** `data_bytes` all 8'h00; `data_ready`=0; `busy`=0; `seq_cnt`=0; `drop_cnt`=0; `ts_cnt`=0; prescaler=0; `pending_valid`=0.
- **Capture to ready:** capture on edge N; bytes 0..30 accumulate on edges N+1..N+31; byte 31 is written and `data_ready` rises on edge N+32. `busy` rises on edge N.
- **Stability:** `data_bytes` change only on capture edges and the byte-31 edge. They never change while `data_ready`=1.
- **Ack to next packet:** `data_ready` falls on the edge that samples `data_ack`. If a pending or simultaneous sample exists, that same edge captures it and the next `data_ready` rises 32 edges later.
- **Throughput:** at most one packet per 33 cycles plus the consumer's ack latency.

## Test plan
- **Basic packet:** `TS_DIV`=1000; release reset; `sample_valid` on the first cycle with all fields 0 and flags 0.
  - `data_ready` rises 32 edges later.
  - Bytes: 0=8'hAA, 1..30=0, 31=8'h56. `busy` is high throughout.
  - `data_ack` → `data_ready` 0 next edge, state IDLE.
- **Field packing:** quat_w=16'h1234, gyro_z=16'hBEEF, flags=8'h81, second packet (seq=1).
  - byte6=8'h12, byte7=8'h34, byte24=8'hBE, byte25=8'hEF, byte26=8'h81, byte1=8'h01.
  - Bytes 0..31 sum to 0 mod 256.
- **Pending and drops:** while in READY send 3 samples A, B, C.
  - On ack, C is captured (A and B overwritten); C's packet shows drop_cnt=2.
  - The next packet shows drop_cnt=0.
  - 300 overwrites report a saturated value of 255.
- **Timestamp:** `TS_DIV`=4; capture on the edge where 40 clk edges have elapsed since reset → timestamp bytes 2–5 = 32'h0000000A.
- **Simultaneous events and spurious ack:**
  - `data_ack` pulsed in IDLE and in BUILD is ignored: no state or output change.
  - READY+`data_ack`+`pending_valid`+`sample_valid` in one cycle → pending sample captured, new sample pending, drop_cnt unchanged.
- **Reset mid-BUILD:** assert `rst_n`=0 at idx 15 → all outputs return to reset values asynchronously. After release, a new sample yields seq=0.

Source files
------------

// File: rtl/sensor_packet_builder.sv
// sensor_packet_builder
// Builds one 32-byte telemetry packet per accepted IMU sample. The sample is
// stamped with a sequence number, timestamp and drop count and then checksummed
// one byte per cycle. The packet is held stable until the SPI stage acks it.
// A single pending register absorbs one sample that arrives while a packet is
// in flight. Any further samples overwrite it and are counted as drops.
//
// state | meaning
// IDLE  | no packet in flight, waiting for sample_valid
// BUILD | bytes 0..30 captured, checksum accumulating one byte per cycle
// READY | packet complete and held, waiting for data_ack
module sensor_packet_builder #(
    parameter int unsigned TS_DIV    = 1000,
    parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] quat_w,
    input  logic [15:0] quat_x,
    input  logic [15:0] quat_y,
    input  logic [15:0] quat_z,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic [7:0]  status_flags,
    output logic [7:0]  data_bytes [0:31],
    output logic        data_ready,
    input  logic        data_ack,
    output logic        busy
);

    localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TS_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        READY = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] qw;
        logic [15:0] qx;
        logic [15:0] qy;
        logic [15:0] qz;
        logic [15:0] ax;
        logic [15:0] ay;
        logic [15:0] az;
        logic [15:0] gx;
        logic [15:0] gy;
        logic [15:0] gz;
        logic [7:0]  fl;
    } sample_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      seq_cnt;
    logic [7:0]      drop_cnt;
    logic [31:0]     ts_cnt;
    logic [PW-1:0]   presc;
    logic            pending_valid;
    sample_t         pend;
    sample_t         live;
    sample_t         cap;
    logic [7:0]      acc;
    logic [4:0]      idx;

    logic            capture;
    logic            cap_pend;
    logic            store_pend;
    logic            drop_evt;
    logic            build_last;

    assign live = {quat_w, quat_x, quat_y, quat_z,
                   accel_x, accel_y, accel_z,
                   gyro_x, gyro_y, gyro_z, status_flags};

    // A capture out of READY takes the pending sample first when there is one.
    assign cap = cap_pend ? pend : live;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_nxt = BUILD;
                end
            end
            BUILD: begin
                if (build_last) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (data_ack) begin
                    if (pending_valid || sample_valid) begin
                        state_nxt = BUILD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output and control decode
    always_comb begin
        capture    = 1'b0;
        cap_pend   = 1'b0;
        store_pend = 1'b0;
        build_last = (idx == 5'd31);
        busy       = (state != IDLE);
        data_ready = (state == READY);
        case (state)
            IDLE: begin
                capture = sample_valid;
            end
            BUILD: begin
                store_pend = sample_valid;
            end
            READY: begin
                if (data_ack) begin
                    if (pending_valid) begin
                        capture    = 1'b1;
                        cap_pend   = 1'b1;
                        store_pend = sample_valid;
                    end else begin
                        capture = sample_valid;
                    end
                end else begin
                    store_pend = sample_valid;
                end
            end
            default: ;
        endcase
        // Refilling a pending slot that is being drained on this edge is not a drop.
        drop_evt = store_pend && pending_valid && !cap_pend;
    end

    // Timestamp prescaler and free-running tick counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ts_cnt <= '0;
        end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            ts_cnt <= ts_cnt + 32'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Sequence and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (capture) begin
                seq_cnt  <= seq_cnt + 8'd1;
                drop_cnt <= drop_evt ? 8'd1 : 8'd0;
            end else if (drop_evt && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Pending-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_valid <= 1'b0;
            pend          <= '0;
        end else if (store_pend) begin
            pending_valid <= 1'b1;
            pend          <= live;
        end else if (cap_pend) begin
            pending_valid <= 1'b0;
        end
    end

    // Packet capture and byte-serial checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                data_bytes[i] <= 8'h00;
            end
            acc <= 8'd0;
            idx <= 5'd0;
        end else if (capture) begin
            data_bytes[0]  <= SYNC_BYTE;
            data_bytes[1]  <= seq_cnt;
            data_bytes[2]  <= ts_cnt[31:24];
            data_bytes[3]  <= ts_cnt[23:16];
            data_bytes[4]  <= ts_cnt[15:8];
            data_bytes[5]  <= ts_cnt[7:0];
            data_bytes[6]  <= cap.qw[15:8];
            data_bytes[7]  <= cap.qw[7:0];
            data_bytes[8]  <= cap.qx[15:8];
            data_bytes[9]  <= cap.qx[7:0];
            data_bytes[10] <= cap.qy[15:8];
            data_bytes[11] <= cap.qy[7:0];
            data_bytes[12] <= cap.qz[15:8];
            data_bytes[13] <= cap.qz[7:0];
            data_bytes[14] <= cap.ax[15:8];
            data_bytes[15] <= cap.ax[7:0];
            data_bytes[16] <= cap.ay[15:8];
            data_bytes[17] <= cap.ay[7:0];
            data_bytes[18] <= cap.az[15:8];
            data_bytes[19] <= cap.az[7:0];
            data_bytes[20] <= cap.gx[15:8];
            data_bytes[21] <= cap.gx[7:0];
            data_bytes[22] <= cap.gy[15:8];
            data_bytes[23] <= cap.gy[7:0];
            data_bytes[24] <= cap.gz[15:8];
            data_bytes[25] <= cap.gz[7:0];
            data_bytes[26] <= cap.fl;
            data_bytes[27] <= drop_cnt;
            data_bytes[28] <= 8'h00;
            data_bytes[29] <= 8'h00;
            data_bytes[30] <= 8'h00;
            acc <= 8'd0;
            idx <= 5'd0;
        end else if (state == BUILD) begin
            // idx 31 is the extra cycle that commits the checksum, so the packet
            // lands exactly 32 edges after capture.
            if (build_last) begin
                data_bytes[31] <= 8'd0 - acc;
            end else begin
                acc <= acc + data_bytes[idx];
                idx <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_packet_builder.sv
// Directed bench for sensor_packet_builder. Stimulus pushes expected packets
// into a queue, and a monitor pops and compares them each time data_ready rises.
module tb_sensor_packet_builder;

    localparam int TS_MAIN = 1000;

    typedef logic [31:0][7:0] pkt_t;
    typedef struct packed {
        logic [15:0] qw, qx, qy, qz, ax, ay, az, gx, gy, gz;
        logic [7:0]  fl;
    } sample_t;

    logic        clk;
    logic        rst_n;
    logic        sample_valid, data_ack, sample_valid4, data_ack4;
    logic [15:0] quat_w, quat_x, quat_y, quat_z;
    logic [15:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
    logic [7:0]  status_flags;
    logic [7:0]  data_bytes  [0:31];
    logic [7:0]  data_bytes4 [0:31];
    logic        data_ready, busy, data_ready4, busy4;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt;
    pkt_t exp_q[$];
    pkt_t exp4_q[$];
    pkt_t cur, expv, held, snap;
    logic rdy_q, rdy4_q;

    sensor_packet_builder #(.TS_DIV(TS_MAIN), .SYNC_BYTE(8'hAA)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .status_flags(status_flags), .data_bytes(data_bytes),
        .data_ready(data_ready), .data_ack(data_ack), .busy(busy)
    );

    sensor_packet_builder #(.TS_DIV(4), .SYNC_BYTE(8'hAA)) dut4 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid4),
        .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .status_flags(status_flags), .data_bytes(data_bytes4),
        .data_ready(data_ready4), .data_ack(data_ack4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges elapsed since reset release, used to predict the timestamp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic pkt_t mk_pkt(input logic [7:0] seq, input logic [31:0] ts,
                                    input sample_t s, input logic [7:0] drop);
        pkt_t p;
        logic [7:0] sum;
        p = '0;
        p[0] = 8'hAA; p[1] = seq;
        p[2] = ts[31:24]; p[3] = ts[23:16]; p[4] = ts[15:8]; p[5] = ts[7:0];
        p[6] = s.qw[15:8];  p[7] = s.qw[7:0];  p[8] = s.qx[15:8];  p[9] = s.qx[7:0];
        p[10] = s.qy[15:8]; p[11] = s.qy[7:0]; p[12] = s.qz[15:8]; p[13] = s.qz[7:0];
        p[14] = s.ax[15:8]; p[15] = s.ax[7:0]; p[16] = s.ay[15:8]; p[17] = s.ay[7:0];
        p[18] = s.az[15:8]; p[19] = s.az[7:0]; p[20] = s.gx[15:8]; p[21] = s.gx[7:0];
        p[22] = s.gy[15:8]; p[23] = s.gy[7:0]; p[24] = s.gz[15:8]; p[25] = s.gz[7:0];
        p[26] = s.fl; p[27] = drop;
        sum = 8'd0;
        for (int i = 0; i < 31; i++) sum = sum + p[i];
        p[31] = 8'd0 - sum;
        return p;
    endfunction

    function automatic sample_t smp(input logic [15:0] b);
        sample_t s;
        s.qw = b;       s.qx = b + 16'd1; s.qy = b + 16'd2; s.qz = b + 16'd3;
        s.ax = b + 16'd4; s.ay = b + 16'd5; s.az = b + 16'd6;
        s.gx = b + 16'd7; s.gy = b + 16'd8; s.gz = b + 16'd9;
        s.fl = b[7:0] ^ 8'h5A;
        return s;
    endfunction

    function automatic pkt_t pack_main();
        pkt_t p;
        for (int i = 0; i < 32; i++) p[i] = data_bytes[i];
        return p;
    endfunction

    function automatic pkt_t pack_four();
        pkt_t p;
        for (int i = 0; i < 32; i++) p[i] = data_bytes4[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic set_fields(input sample_t s);
        quat_w = s.qw; quat_x = s.qx; quat_y = s.qy; quat_z = s.qz;
        accel_x = s.ax; accel_y = s.ay; accel_z = s.az;
        gyro_x = s.gx; gyro_y = s.gy; gyro_z = s.gz;
        status_flags = s.fl;
    endtask

    // One-cycle sample strobe; when push is set the capture is predicted here.
    task automatic strobe(input bit push, input sample_t s, input logic [7:0] seq,
                          input logic [7:0] drop);
        @(negedge clk);
        if (push) exp_q.push_back(mk_pkt(seq, edge_cnt / TS_MAIN, s, drop));
        set_fields(s);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic ack(input bit push, input sample_t s, input logic [7:0] seq,
                       input logic [7:0] drop);
        @(negedge clk);
        if (push) exp_q.push_back(mk_pkt(seq, edge_cnt / TS_MAIN, s, drop));
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    // Counts edges from capture to data_ready; optionally pulses a spurious ack mid-build.
    task automatic wait_ready(input string name, input int ack_at);
        int  n;
        bit  busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!data_ready && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            data_ack = (n == ack_at);
            if (!data_ready && !busy) busy_ok = 1'b0;
        end
        data_ack = 1'b0;
        chk({name, "_latency"}, 256'(n), 256'd32);
        chk({name, "_busy"}, 256'(busy_ok), 256'd1);
    endtask

    // Scoreboard monitor for the main instance, plus a hold-stability check.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            if (data_ready && !rdy_q) begin
                cur = pack_main();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_unexpected got %0h", cur);
                end else begin
                    expv = exp_q.pop_front();
                    if (cur !== expv) begin
                        errors++;
                        $display("FAIL pkt got %0h exp %0h", cur, expv);
                    end
                end
                held = cur;
            end else if (data_ready) begin
                cur = pack_main();
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL pkt_stable got %0h exp %0h", cur, held);
                end
            end
            rdy_q <= data_ready;
        end
    end

    // Scoreboard monitor for the fast-timestamp instance.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy4_q <= 1'b0;
        end else begin
            if (data_ready4 && !rdy4_q) begin
                cur = pack_four();
                checks++;
                if (exp4_q.size() == 0) begin
                    errors++;
                    $display("FAIL pkt4_unexpected got %0h", cur);
                end else begin
                    expv = exp4_q.pop_front();
                    if (cur !== expv) begin
                        errors++;
                        $display("FAIL pkt4 got %0h exp %0h", cur, expv);
                    end
                end
            end
            rdy4_q <= data_ready4;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        sample_t s0, s2, sa, sb, sc, sd, se, sf, sg, sh, si, sj, sk;
        logic [7:0] sm;
        int n;
        s0 = '0;
        s2 = '0;
        s2.qw = 16'h1234; s2.qx = 16'h00FF; s2.ay = 16'h7F80;
        s2.gz = 16'hBEEF; s2.fl = 8'h81;
        sa = smp(16'h1000); sb = smp(16'h2000); sc = smp(16'h3000);
        sd = smp(16'h4000); se = smp(16'h5000); sf = smp(16'h6000);
        sg = smp(16'h7000); sh = smp(16'h8000); si = smp(16'h9000);
        sj = smp(16'hA000); sk = smp(16'hB000);

        rst_n = 1'b0;
        sample_valid = 1'b0; data_ack = 1'b0;
        sample_valid4 = 1'b0; data_ack4 = 1'b0;
        set_fields(s0);
        repeat (2) @(negedge clk);
        chk("reset_ready", 256'(data_ready), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_bytes", pack_main(), 256'd0);

        // Basic packet: sample on the first cycle after reset release.
        exp_q.push_back(mk_pkt(8'd0, 32'd0, s0, 8'd0));
        rst_n = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_ready("basic", 0);
        chk("basic_byte0", 256'(data_bytes[0]), 256'hAA);
        chk("basic_byte31", 256'(data_bytes[31]), 256'h56);
        ack(1'b0, s0, 8'd0, 8'd0);
        chk("basic_ack_ready", 256'(data_ready), 256'd0);
        chk("basic_ack_busy", 256'(busy), 256'd0);

        // Spurious ack in IDLE.
        snap = pack_main();
        ack(1'b0, s0, 8'd0, 8'd0);
        @(negedge clk);
        chk("idle_ack_ready", 256'(data_ready), 256'd0);
        chk("idle_ack_busy", 256'(busy), 256'd0);
        chk("idle_ack_bytes", pack_main(), snap);

        // Field packing, with a spurious ack mid-build.
        strobe(1'b1, s2, 8'd1, 8'd0);
        wait_ready("fields", 10);
        chk("fields_b1", 256'(data_bytes[1]), 256'h01);
        chk("fields_b6", 256'(data_bytes[6]), 256'h12);
        chk("fields_b7", 256'(data_bytes[7]), 256'h34);
        chk("fields_b24", 256'(data_bytes[24]), 256'hBE);
        chk("fields_b25", 256'(data_bytes[25]), 256'hEF);
        chk("fields_b26", 256'(data_bytes[26]), 256'h81);
        sm = 8'd0;
        for (int i = 0; i < 32; i++) sm = sm + data_bytes[i];
        chk("fields_sum", 256'(sm), 256'd0);
        ack(1'b0, s0, 8'd0, 8'd0);

        // Pending and drops: A, B, C arrive in READY; C wins with drop_cnt 2.
        strobe(1'b1, sd, 8'd2, 8'd0);
        wait_ready("pend_first", 0);
        strobe(1'b0, sa, 8'd0, 8'd0);
        strobe(1'b0, sb, 8'd0, 8'd0);
        strobe(1'b0, sc, 8'd0, 8'd0);
        ack(1'b1, sc, 8'd3, 8'd2);
        chk("pend_ack_ready", 256'(data_ready), 256'd0);
        chk("pend_ack_busy", 256'(busy), 256'd1);
        wait_ready("pend_c", 0);
        ack(1'b0, s0, 8'd0, 8'd0);
        strobe(1'b1, se, 8'd4, 8'd0);
        wait_ready("pend_after", 0);

        // 300 overwrites saturate the drop count.
        @(negedge clk);
        set_fields(sf);
        sample_valid = 1'b1;
        repeat (301) @(negedge clk);
        sample_valid = 1'b0;
        ack(1'b1, sf, 8'd5, 8'd255);
        wait_ready("saturate", 0);
        ack(1'b0, s0, 8'd0, 8'd0);

        // READY + ack + pending + new sample in one cycle.
        strobe(1'b1, sg, 8'd6, 8'd0);
        wait_ready("simul_first", 0);
        strobe(1'b0, sh, 8'd0, 8'd0);
        @(negedge clk);
        exp_q.push_back(mk_pkt(8'd7, edge_cnt / TS_MAIN, sh, 8'd0));
        set_fields(si);
        sample_valid = 1'b1;
        data_ack = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        data_ack = 1'b0;
        wait_ready("simul_h", 0);
        ack(1'b1, si, 8'd8, 8'd0);
        wait_ready("simul_i", 0);
        ack(1'b0, s0, 8'd0, 8'd0);
        chk("simul_idle", 256'(busy), 256'd0);

        // Reset in the middle of a build.
        strobe(1'b1, sj, 8'd9, 8'd0);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        chk("midrst_ready", 256'(data_ready), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_bytes", pack_main(), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(1'b1, sk, 8'd0, 8'd0);
        wait_ready("after_rst", 0);
        chk("after_rst_seq", 256'(data_bytes[1]), 256'd0);
        ack(1'b0, s0, 8'd0, 8'd0);

        // Timestamp with TS_DIV=4: capture after 40 edges sees tick 10.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (edge_cnt != 40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp4_q.push_back(mk_pkt(8'd0, 32'h0000000A, s2, 8'd0));
        set_fields(s2);
        sample_valid4 = 1'b1;
        @(negedge clk);
        sample_valid4 = 1'b0;
        n = 0;
        while (!data_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ts_ready", 256'(data_ready4), 256'd1);
        chk("ts_bytes", {data_bytes4[2], data_bytes4[3], data_bytes4[4], data_bytes4[5]},
            256'h0000000A);
        @(negedge clk);
        data_ack4 = 1'b1;
        @(negedge clk);
        data_ack4 = 1'b0;
        chk("ts_ack_ready", 256'(data_ready4), 256'd0);

        repeat (3) @(negedge clk);
        chk("queue_main_empty", 256'(exp_q.size()), 256'd0);
        chk("queue_ts_empty", 256'(exp4_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
